// File: rtl/mdu_seq.sv
// mdu_seq: iterative MIPS multiply/divide sequencer with a HI/LO register pair.
// Define MDU_DIV_EN to build the DIV/DIVU path; otherwise only MULT/MULTU/MTHI/MTLO are supported.
module mdu_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic        done,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
`ifdef MDU_DIV_EN
  localparam logic [2:0] OP_DIVU  = 3'b100;
`endif
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;
  state_t r_state, w_next;

  logic [63:0]   r_acc;
  logic [31:0]   r_init;
  logic [31:0]   r_opd;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [CW-1:0] r_cnt;
  logic          r_negRes;
`ifdef MDU_DIV_EN
  logic          r_isDiv;
  logic          r_negRem;
  logic          r_divZero;
  logic          w_divOk;
  logic [31:0]   w_quot;
  logic [31:0]   w_rem;
`endif

  logic        w_isMul;
  logic        w_isDiv;
  logic        w_signed;
  logic        w_accept;
  logic [31:0] w_rsMag;
  logic [31:0] w_rtMag;
  logic [32:0] w_sum;
  logic [32:0] w_mulHi;
  logic [63:0] w_accStep;
  logic [63:0] w_prod;

  assign w_isMul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
`ifdef MDU_DIV_EN
  assign w_isDiv = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
`else
  assign w_isDiv = 1'b0;
`endif
  assign w_signed = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
  assign w_accept = (r_state == S_IDLE) && start && (w_isMul || w_isDiv) && !flush;
  assign w_rsMag  = (w_signed && rs_val[31]) ? -rs_val : rs_val;
  assign w_rtMag  = (w_signed && rt_val[31]) ? -rt_val : rt_val;

  // Shared 33-bit adder; divide feeds it the shifted partial remainder without its carry-out bit.
`ifdef MDU_DIV_EN
  always_comb begin
    if (r_isDiv) begin
      w_sum   = {1'b0, r_acc[62:31]} - {1'b0, r_opd};
      w_divOk = r_acc[63] || !w_sum[32];
    end else begin
      w_sum   = {1'b0, r_acc[63:32]} + {1'b0, r_opd};
      w_divOk = 1'b0;
    end
  end
`else
  assign w_sum = {1'b0, r_acc[63:32]} + {1'b0, r_opd};
`endif

  always_comb begin
    w_mulHi   = r_acc[0] ? w_sum : {1'b0, r_acc[63:32]};
    w_accStep = {w_mulHi, r_acc[31:1]};
`ifdef MDU_DIV_EN
    if (r_isDiv)
      w_accStep = w_divOk ? {w_sum[31:0], r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};
`endif
  end

  assign w_prod = r_negRes ? -r_acc : r_acc;
`ifdef MDU_DIV_EN
  assign w_quot = r_divZero ? 32'hFFFF_FFFF : (r_negRes ? -r_acc[31:0] : r_acc[31:0]);
  assign w_rem  = r_negRem ? -r_acc[63:32] : r_acc[63:32];
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_accept;
        if (w_accept) w_next = S_PREP;
      end
      S_PREP: begin
        stall  = 1'b1;
        w_next = flush ? S_IDLE : S_CALC;
      end
      S_CALC: begin
        stall = 1'b1;
        if (flush)              w_next = S_IDLE;
        else if (r_cnt == LAST) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_FIX) && !flush;
  assign hi_o = r_hi;
  assign lo_o = r_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_init   <= '0;
      r_opd    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_negRes <= 1'b0;
`ifdef MDU_DIV_EN
      r_isDiv   <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_init   <= w_isDiv ? w_rsMag : w_rtMag;
            r_opd    <= w_isDiv ? w_rtMag : w_rsMag;
            r_negRes <= w_signed && (rs_val[31] ^ rt_val[31]);
`ifdef MDU_DIV_EN
            r_isDiv   <= w_isDiv;
            r_negRem  <= w_signed && rs_val[31];
            r_divZero <= (rt_val == 32'h0);
`endif
          end else if (start && !flush) begin
            if (mdu_op == OP_MTHI) r_hi <= rs_val;
            if (mdu_op == OP_MTLO) r_lo <= rs_val;
          end
        end
        S_PREP: begin
          r_acc <= {32'h0, r_init};
          r_cnt <= '0;
        end
        S_CALC: begin
          r_acc <= w_accStep;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          if (!flush) begin
`ifdef MDU_DIV_EN
            if (r_isDiv) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end else
`endif
            begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq (vector table, corner sequences, random ops vs. arithmetic model).
// Honours MDU_DIV_EN the same way the design does.
module tb_mdu_seq;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam int OP_CYCLES = 34;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        stall;
  logic        done;
  logic        busy;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] mHi = 32'h0;
  logic [31:0] mLo = 32'h0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[$];

  mdu_seq #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .mdu_op(mdu_op),
    .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .done(done), .busy(busy),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Plain-arithmetic reference: returns {HI, LO} for a mul/div op.
  function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    longint pa, pb;
    int qa, qb;
    r = '0;
    case (op)
      OP_MULT: begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        r  = 64'(pa * pb);
      end
      OP_MULTU: r = {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          qa = $signed(a);
          qb = $signed(b);
          r  = {32'(qa % qb), 32'(qa / qb)};
        end
      end
      OP_DIVU: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic applyStimulus(input logic s, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic f);
    start  = s;
    mdu_op = op;
    rs_val = a;
    rt_val = b;
    flush  = f;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string n, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] e);
    vec_t v;
    v.name = n; v.op = op; v.rs = a; v.rt = b; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Full mul/div transaction; entered and left just after a rising edge.
  task automatic runMulDiv(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
    int stallCnt = 0;
    int doneCyc  = -1;
    applyStimulus(1'b1, op, a, b, 1'b0);
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (stall) stallCnt++;
      if (cyc == 1) checkOutput({name, "/busy"}, 64'(busy), 64'd1);
      if (done && doneCyc < 0) doneCyc = cyc;
      nextCycle();
      if (cyc == 0) applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
      if (doneCyc >= 0) break;
    end
    checkOutput({name, "/stallCycles"}, 64'(stallCnt), 64'(OP_CYCLES));
    checkOutput({name, "/doneCycle"}, 64'(doneCyc), 64'(OP_CYCLES));
    checkOutput({name, "/hilo"}, {hi_o, lo_o}, exp);
    {mHi, mLo} = exp;
  endtask

  // Op that must behave as "none": no stall, no busy, no done, HI/LO untouched.
  task automatic runNoOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int activity = 0;
    applyStimulus(1'b1, op, a, b, 1'b0);
    @(negedge clk);
    checkOutput({name, "/stall"}, 64'(stall), 64'd0);
    nextCycle();
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || done || stall) activity++;
      nextCycle();
    end
    checkOutput({name, "/activity"}, 64'(activity), 64'd0);
    checkOutput({name, "/hilo"}, {hi_o, lo_o}, {mHi, mLo});
  endtask

  task automatic writeHiLo(input logic [31:0] h, input logic [31:0] l);
    applyStimulus(1'b1, OP_MTHI, h, 32'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, OP_MTLO, l, 32'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    mHi = h;
    mLo = l;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int doneCnt;

    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset/hilo", {hi_o, lo_o}, 64'h0);
    checkOutput("reset/flags", {61'h0, stall, busy, done}, 64'h0);
    nextCycle();
    rst = 1'b0;

    // Vector table: spec corner values with hand-derived results.
    addVec("mult_m2x3",    OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
    addVec("multu_m2x3",   OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 64'h0000_0002_FFFF_FFFA);
    addVec("mult_minsq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    addVec("multu_maxsq",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    addVec("mult_m1xm1",   OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    addVec("mult_0xm1",    OP_MULT,  32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000);
    addVec("div_m7by2",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
    addVec("divu_7by0",    OP_DIVU,  32'h0000_0007, 32'h0000_0000, 64'h0000_0007_FFFF_FFFF);
    addVec("div_ovf",      OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    addVec("div_m7by0",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF);
    addVec("divu_bigdvsr", OP_DIVU,  32'hFFFF_FFFF, 32'h8000_0000, 64'h7FFF_FFFF_0000_0001);
    addVec("div_7bym2",    OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);

    foreach (vecs[i]) begin
`ifdef MDU_DIV_EN
      runMulDiv(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp);
`else
      if (vecs[i].op == OP_DIV || vecs[i].op == OP_DIVU)
        runNoOp(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt);
      else
        runMulDiv(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp);
`endif
    end

    // MTHI then MTLO back to back: no stall, each visible one cycle later.
    applyStimulus(1'b1, OP_MTHI, 32'h1234_5678, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("mthi/stall", 64'(stall), 64'd0);
    nextCycle();
    applyStimulus(1'b1, OP_MTLO, 32'h9ABC_DEF0, 32'h0, 1'b0);
    checkOutput("mthi/hi", 64'(hi_o), 64'h1234_5678);
    @(negedge clk);
    checkOutput("mtlo/stall", 64'(stall), 64'd0);
    nextCycle();
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    checkOutput("mtlo/hilo", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);
    mHi = 32'h1234_5678;
    mLo = 32'h9ABC_DEF0;

    // Flush in IDLE squashes a same-cycle MTHI.
    applyStimulus(1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    checkOutput("flushIdle/hilo", {hi_o, lo_o}, {mHi, mLo});

    // Flush during CALC iteration 10 of a MULT.
    writeHiLo(32'h11, 32'h22);
    doneCnt = 0;
    applyStimulus(1'b1, OP_MULT, 32'h0000_1234, 32'h0000_5678, 1'b0);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (done) doneCnt++;
      nextCycle();
      if (cyc == 1) applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    end
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flushCalc/busyBefore", 64'(busy), 64'd1);
    nextCycle();
    flush = 1'b0;
    checkOutput("flushCalc/idleAfter", {62'h0, busy, stall}, 64'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) doneCnt++;
      nextCycle();
    end
    checkOutput("flushCalc/doneCount", 64'(doneCnt), 64'd0);
    checkOutput("flushCalc/hilo", {hi_o, lo_o}, 64'h0000_0011_0000_0022);
    runMulDiv("afterFlush_multu", OP_MULTU, 32'h0001_0001, 32'h0000_FFFF,
              refModel(OP_MULTU, 32'h0001_0001, 32'h0000_FFFF));

    // Hold start/op through FIX, then a new op right after FIX is accepted.
    doneCnt = 0;
    applyStimulus(1'b1, OP_MULT, 32'hFFFF_FFF0, 32'h0000_0100, 1'b0);
    for (int cyc = 0; cyc <= OP_CYCLES; cyc++) begin
      @(negedge clk);
      if (done) doneCnt++;
      nextCycle();
    end
    applyStimulus(1'b1, OP_MTLO, 32'hCAFE_F00D, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("hold/stallAfterFix", 64'(stall), 64'd0);
    nextCycle();
    applyStimulus(1'b0, OP_NONE, 32'h0, 32'h0, 1'b0);
    checkOutput("hold/hilo", {hi_o, lo_o}, {refModel(OP_MULT, 32'hFFFF_FFF0, 32'h0000_0100) >> 32, 32'hCAFE_F00D} & 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) doneCnt++;
      nextCycle();
    end
    checkOutput("hold/doneCount", 64'(doneCnt), 64'd1);
    mHi = hi_o;
    mHi = refModel(OP_MULT, 32'hFFFF_FFF0, 32'h0000_0100) >> 32;
    mLo = 32'hCAFE_F00D;

    // Random operations against the reference model.
    for (int n = 0; n < 16; n++) begin
`ifdef MDU_DIV_EN
      case ($urandom_range(0, 3))
        0:       rop = OP_MULT;
        1:       rop = OP_MULTU;
        2:       rop = OP_DIV;
        default: rop = OP_DIVU;
      endcase
`else
      rop = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU;
`endif
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      runMulDiv($sformatf("rand%0d", n), rop, ra, rb, refModel(rop, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
